eprisc_bus_arbiter: RTL and testbench
=====================================

# eprisc_bus_arbiter

Round-robin arbiter and sequencer for the I/O controller's internal peripheral bus (15-bit address, 16-bit data, write strobe). It shares that bus between several masters (host byte-pipeline, future DMA and boot sequencer), grants one at a time, and runs each access to completion with a ready handshake. It supports locked multi-access bursts and an optional hung-peripheral timeout. It sits between the masters and the GPIO/UART/SPI/RAM address decode.

## Interface
- NUM_REQ, 4, number of masters (2..8)
- ADDR_W, 15, bus address width
- DATA_W, 16, bus data width
- TIMEOUT, 64, cycles without ready before abort (timeout build only)

- iBusClock  in  1  sole clock; everything is rising-edge
- iBoardReset  in  1  reset; asynchronous, active-low
- iReq  in  NUM_REQ  per-master access request, level
- iLock  in  NUM_REQ  per-master hold-bus-after-ack
- iWrite  in  NUM_REQ  per-master write flag
- iAddr  in  NUM_REQ*ADDR_W  packed addresses, master k at [k*ADDR_W +: ADDR_W]
- iData  in  NUM_REQ*DATA_W  packed write data, same packing
- iBusReady  in  1  addressed peripheral completed the access
- iBusMISO  in  32  read data from the peripheral
- oGrant  out  NUM_REQ  one-hot owner, registered
- oAck  out  NUM_REQ  one-cycle completion pulse to the owner
- oError  out  NUM_REQ  one-cycle timeout pulse to the owner
- oRdata  out  32  iBusMISO captured on ack, held until next ack
- oBusAddress  out  ADDR_W  muxed owner address
- oBusData  out  DATA_W  muxed owner data
- oBusWrite  out  1  owner iWrite qualified by the ACCESS state
- oBusValid  out  1  access in progress

## Operation
- States: IDLE, ACCESS, HOLD.
- IDLE: all outputs 0. If any iReq is set, the rotating-priority pick starts at (rLast+1) mod NUM_REQ, then wraps. The winner is registered into oGrant and the state moves to ACCESS.
- ACCESS: oBusValid=1. The bus mirrors the owner's iAddr/iData/iWrite combinationally, and the owner holds them stable until ack. On iBusReady: pulse oAck[owner], capture oRdata, set rLast=owner. Then go to HOLD if iLock[owner]=1, else go to IDLE and clear oGrant.
- HOLD: grant is kept and oBusValid=0. If iReq[owner]=1, go to ACCESS with no arbitration. Else if iLock[owner]=0, go to IDLE. Other requests are ignored while in HOLD.
- The owner dropping iReq during ACCESS is illegal. The arbiter still waits for ready (or timeout).
- Only one oAck or oError bit is ever set, and only in the cycle after completion.
- Reset (any state, including mid-ACCESS): state=IDLE, rLast=NUM_REQ-1 (so master 0 wins first), all outputs 0, oRdata=0, timeout counter=0.

## Timing
- iReq set in IDLE at edge n → oGrant and oBusValid high after edge n+1. Minimum latency 1 cycle.
- iBusReady sampled high at edge m → oAck high for cycle m..m+1. Next-grant earliest after edge m+1, so back-to-back accesses from different masters take 2 cycles each with zero-wait peripherals.
- Locked burst: one access per 2 cycles (ACCESS→HOLD→ACCESS). A request held through HOLD re-enters ACCESS at the next edge.
- iBusReady outside ACCESS is ignored.

## Configuration
- ARB_TIMEOUT_EN defined: a counter runs in ACCESS and clears on entry.
  - When it reaches TIMEOUT-1 without ready: pulse oError[owner], no oAck, oRdata unchanged, rLast=owner, go to IDLE. Lock is discarded.
  - Ready and timeout in the same cycle: ready wins.
- Not defined: no counter, ACCESS waits indefinitely, oError tied 0.

## Structure
- Shared package/include: state encodings `sArbIdle, `sArbAccess, `sArbHold, and the default TIMEOUT.
- One sub-module: eprisc_rr_picker. It is combinational: request vector plus last-owner index in, one-hot winner out, implemented as a rotate–priority-encode–rotate-back.

## Test plan
- Single master: iReq[2]=1, iAddr=15'h123, iData=16'hBEEF, iWrite=1, ready after 3 cycles → oGrant=4'b0100 one cycle after the request. Bus shows 123/BEEF/write for 3 cycles, oAck[2] pulses once, then IDLE.
- All four requesting continuously with zero-wait ready → grants in order 0,1,2,3,0 at a 2-cycle spacing, each oAck one cycle.
- Lock: master 1 with iLock=1 does 3 reads (iBusMISO=32'h11111111, 22222222, 33333333) while master 0 requests → oRdata follows each value. Master 0 is granted only after iLock[1] drops.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=8): ready never asserted → oError[owner] pulses exactly 8 cycles after ACCESS entry, and the next master is granted.
- Ready and timeout in the same cycle → oAck, not oError.
- Reset asserted mid-ACCESS → all outputs 0 asynchronously. After release, master 0 wins the first arbitration.

Source files
------------

// File: rtl/eprisc_bus_arbiter_pkg.sv
// Shared definitions for the peripheral-bus arbiter: sequencer states and
// the default hung-peripheral timeout.
package eprisc_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    sArbIdle   = 2'd0,
    sArbAccess = 2'd1,
    sArbHold   = 2'd2
  } arbState_t;

  localparam int unsigned ARB_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/eprisc_rr_picker.sv
// Combinational round-robin picker: rotate requests so the slot after the
// last owner is bit 0, priority-encode, then rotate the winner back.
module eprisc_rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] iReq,
  input  logic [IDX_W-1:0]   iLast,
  output logic [NUM_REQ-1:0] oGrant,
  output logic [IDX_W-1:0]   oIndex
);

  always_comb begin
    logic [NUM_REQ-1:0] rotated;
    int unsigned        start;
    int unsigned        hit;
    int unsigned        win;
    int unsigned        src;
    logic               found;

    start = 32'(iLast) + 32'd1;
    if (start >= NUM_REQ) start = 0;

    rotated = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      src = i + start;
      if (src >= NUM_REQ) src = src - NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (j == src) rotated[i] = iReq[j];
      end
    end

    found = 1'b0;
    hit   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && rotated[i]) begin
        found = 1'b1;
        hit   = i;
      end
    end

    win = hit + start;
    if (win >= NUM_REQ) win = win - NUM_REQ;

    oGrant = '0;
    oIndex = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (found && (j == win)) begin
        oGrant[j] = 1'b1;
        oIndex    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/eprisc_bus_arbiter.sv
// Round-robin arbiter/sequencer for the internal peripheral bus with locked
// bursts. Define ARB_TIMEOUT_EN to abort accesses whose peripheral never readies.
module eprisc_bus_arbiter
  import eprisc_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic                      iBusClock,
  input  logic                      iBoardReset,
  input  logic [NUM_REQ-1:0]        iReq,
  input  logic [NUM_REQ-1:0]        iLock,
  input  logic [NUM_REQ-1:0]        iWrite,
  input  logic [NUM_REQ*ADDR_W-1:0] iAddr,
  input  logic [NUM_REQ*DATA_W-1:0] iData,
  input  logic                      iBusReady,
  input  logic [31:0]               iBusMISO,
  output logic [NUM_REQ-1:0]        oGrant,
  output logic [NUM_REQ-1:0]        oAck,
  output logic [NUM_REQ-1:0]        oError,
  output logic [31:0]               oRdata,
  output logic [ADDR_W-1:0]         oBusAddress,
  output logic [DATA_W-1:0]         oBusData,
  output logic                      oBusWrite,
  output logic                      oBusValid
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arbState_t          rState;
  logic [IDX_W-1:0]   rOwner;
  logic [IDX_W-1:0]   rLast;
  logic [IDX_W-1:0]   pickIdx;
  logic [NUM_REQ-1:0] pickGrant;
  logic               inAccess;
  logic               timedOut;
  logic               ownerReq;
  logic               ownerLock;
  logic               ownerWrite;
  logic [ADDR_W-1:0]  ownerAddr;
  logic [DATA_W-1:0]  ownerData;

  eprisc_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) uPicker (
    .iReq   (iReq),
    .iLast  (rLast),
    .oGrant (pickGrant),
    .oIndex (pickIdx)
  );

  // oGrant is one-hot (or zero), so OR-ing the masked fields selects the owner.
  always_comb begin
    ownerAddr = '0;
    ownerData = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (oGrant[k]) begin
        ownerAddr = ownerAddr | iAddr[k*ADDR_W +: ADDR_W];
        ownerData = ownerData | iData[k*DATA_W +: DATA_W];
      end
    end
  end

  assign ownerReq    = |(iReq & oGrant);
  assign ownerLock   = |(iLock & oGrant);
  assign ownerWrite  = |(iWrite & oGrant);
  assign inAccess    = (rState == sArbAccess);
  assign oBusValid   = inAccess;
  assign oBusWrite   = inAccess & ownerWrite;
  assign oBusAddress = inAccess ? ownerAddr : '0;
  assign oBusData    = inAccess ? ownerData : '0;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] rWaitCnt;

  // Ready in the final cycle takes precedence over the abort.
  assign timedOut = inAccess && !iBusReady && (rWaitCnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge iBusClock or negedge iBoardReset) begin
    if (!iBoardReset) begin
      rWaitCnt <= '0;
      oError   <= '0;
    end else begin
      oError   <= timedOut ? oGrant : '0;
      rWaitCnt <= inAccess ? rWaitCnt + 1'b1 : '0;
    end
  end
`else
  assign timedOut = 1'b0;
  assign oError   = '0;
`endif

  always_ff @(posedge iBusClock or negedge iBoardReset) begin
    if (!iBoardReset) begin
      rState <= sArbIdle;
      oGrant <= '0;
      rOwner <= '0;
      rLast  <= IDX_W'(NUM_REQ - 1);
      oAck   <= '0;
      oRdata <= '0;
    end else begin
      oAck <= '0;
      case (rState)
        sArbIdle: begin
          if (|iReq) begin
            oGrant <= pickGrant;
            rOwner <= pickIdx;
            rState <= sArbAccess;
          end
        end
        sArbAccess: begin
          if (iBusReady) begin
            oAck   <= oGrant;
            oRdata <= iBusMISO;
            rLast  <= rOwner;
            if (ownerLock) begin
              rState <= sArbHold;
            end else begin
              rState <= sArbIdle;
              oGrant <= '0;
            end
          end else if (timedOut) begin
            rLast  <= rOwner;
            rState <= sArbIdle;
            oGrant <= '0;
          end
        end
        sArbHold: begin
          if (ownerReq) begin
            rState <= sArbAccess;
          end else if (!ownerLock) begin
            rState <= sArbIdle;
            oGrant <= '0;
          end
        end
        default: begin
          rState <= sArbIdle;
          oGrant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eprisc_bus_arbiter.sv
// Bench for eprisc_bus_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the arbitration rules.
module tb_eprisc_bus_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 15;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rstN;
  logic [N-1:0]  req, lock, wr;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] data;
  logic          ready;
  logic [31:0]   miso;
  logic [N-1:0]  grant, ack, err;
  logic [31:0]   rdata;
  logic [AW-1:0] busAddr;
  logic [DW-1:0] busData;
  logic          busWrite, busValid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  eprisc_bus_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .iBusClock   (clk),
    .iBoardReset (rstN),
    .iReq        (req),
    .iLock       (lock),
    .iWrite      (wr),
    .iAddr       (addr),
    .iData       (data),
    .iBusReady   (ready),
    .iBusMISO    (miso),
    .oGrant      (grant),
    .oAck        (ack),
    .oError      (err),
    .oRdata      (rdata),
    .oBusAddress (busAddr),
    .oBusData    (busData),
    .oBusWrite   (busWrite),
    .oBusValid   (busValid)
  );

  task automatic do_reset();
    rstN = 1'b0; req = '0; lock = '0; wr = '0; addr = '0; data = '0;
    ready = 1'b0; miso = '0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
    checks++; if (ack !== 4'b0000 || err !== 4'b0000) begin errors++; $display("FAIL reset_ack_err: got %b/%b want 0000/0000", ack, err); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if ({busValid, busWrite, busAddr, busData} !== '0) begin errors++; $display("FAIL reset_bus: got v=%b w=%b a=%h d=%h want zeros", busValid, busWrite, busAddr, busData); end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100; wr = 4'b0100;
    addr[2*AW +: AW] = 15'h123; data[2*DW +: DW] = 16'hBEEF;
    @(negedge clk);
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", grant); end
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if (busValid !== 1'b1 || busWrite !== 1'b1) begin errors++; $display("FAIL single_valid_write c=%0d: got %b%b want 11", c, busValid, busWrite); end
      checks++; if (busAddr !== 15'h123 || busData !== 16'hBEEF) begin errors++; $display("FAIL single_bus c=%0d: got %h/%h want 123/beef", c, busAddr, busData); end
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_noack c=%0d: got %b want 0000", c, ack); end
      if (c == 2) ready = 1'b1;
    end
    @(negedge clk);
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b want 0100", ack); end
    checks++; if (grant !== 4'b0000 || busValid !== 1'b0) begin errors++; $display("FAIL single_idle: got grant=%b valid=%b want 0000/0", grant, busValid); end
    req = '0; ready = 1'b0;
    @(negedge clk);
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_pulse: got %b want 0000", ack); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] expG, expA;
    do_reset();
    req = 4'b1111; ready = 1'b1;
    for (int s = 0; s < 9; s++) begin
      @(negedge clk);
      expG = (s % 2 == 0) ? 4'(4'b0001 << ((s / 2) % 4)) : 4'b0000;
      expA = (s % 2 == 1) ? 4'(4'b0001 << ((s / 2) % 4)) : 4'b0000;
      checks++; if (grant !== expG) begin errors++; $display("FAIL rr_grant s=%0d: got %b want %b", s, grant, expG); end
      checks++; if (ack !== expA) begin errors++; $display("FAIL rr_ack s=%0d: got %b want %b", s, ack, expA); end
    end
    req = '0; ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_lock();
    logic [31:0] vals [3];
    vals[0] = 32'h11111111; vals[1] = 32'h22222222; vals[2] = 32'h33333333;
    do_reset();
    req = 4'b0010; lock = 4'b0010;
    @(negedge clk);
    req = 4'b0011;
    for (int b = 0; b < 3; b++) begin
      checks++; if (grant !== 4'b0010 || busValid !== 1'b1) begin errors++; $display("FAIL lock_access b=%0d: got grant=%b valid=%b want 0010/1", b, grant, busValid); end
      ready = 1'b1; miso = vals[b];
      @(negedge clk);
      ready = 1'b0; miso = '0;
      checks++; if (ack !== 4'b0010 || rdata !== vals[b]) begin errors++; $display("FAIL lock_ack b=%0d: got ack=%b rdata=%h want 0010/%h", b, ack, rdata, vals[b]); end
      checks++; if (grant !== 4'b0010 || busValid !== 1'b0) begin errors++; $display("FAIL lock_hold b=%0d: got grant=%b valid=%b want 0010/0", b, grant, busValid); end
      if (b < 2) @(negedge clk);
    end
    req = 4'b0001;
    @(negedge clk);
    checks++; if (grant !== 4'b0010 || busValid !== 1'b0) begin errors++; $display("FAIL lock_keep: got grant=%b valid=%b want 0010/0", grant, busValid); end
    lock = 4'b0000;
    @(negedge clk);
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL lock_release: got %b want 0000", grant); end
    @(negedge clk);
    checks++; if (grant !== 4'b0001 || rdata !== 32'h33333333) begin errors++; $display("FAIL lock_next: got grant=%b rdata=%h want 0001/33333333", grant, rdata); end
    req = '0; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL lock_next_ack: got %b want 0001", ack); end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    req = 4'b0100; wr = 4'b0100; addr[2*AW +: AW] = 15'h7abc;
    @(negedge clk);
    checks++; if (busValid !== 1'b1) begin errors++; $display("FAIL midrst_pre: got valid=%b want 1", busValid); end
    #2 rstN = 1'b0;
    #1;
    checks++; if ({grant, ack, err, busValid, busWrite, busAddr, busData, rdata} !== '0) begin errors++; $display("FAIL midrst_async: got grant=%b ack=%b valid=%b addr=%h want zeros", grant, ack, busValid, busAddr); end
    @(negedge clk);
    rstN = 1'b1; req = 4'b1111;
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL midrst_first: got %b want 0001", grant); end
    req = '0; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req = 4'b0011;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      checks++; if (err !== 4'b0000 || grant !== 4'b0001) begin errors++; $display("FAIL to_wait j=%0d: got err=%b grant=%b want 0000/0001", j, err, grant); end
    end
    @(negedge clk);
    checks++; if (err !== 4'b0001 || ack !== 4'b0000) begin errors++; $display("FAIL to_error: got err=%b ack=%b want 0001/0000", err, ack); end
    checks++; if (grant !== 4'b0000 || rdata !== 32'h0) begin errors++; $display("FAIL to_idle: got grant=%b rdata=%h want 0000/0", grant, rdata); end
    @(negedge clk);
    checks++; if (grant !== 4'b0010 || err !== 4'b0000) begin errors++; $display("FAIL to_next: got grant=%b err=%b want 0010/0000", grant, err); end
    req = '0; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout_tie();
    do_reset();
    req = 4'b0001; miso = 32'hA5A50001;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (j == 8) ready = 1'b1;
    end
    @(negedge clk);
    ready = 1'b0; req = '0;
    checks++; if (ack !== 4'b0001 || err !== 4'b0000) begin errors++; $display("FAIL to_tie: got ack=%b err=%b want 0001/0000", ack, err); end
    checks++; if (rdata !== 32'hA5A50001) begin errors++; $display("FAIL to_tie_rdata: got %h want a5a50001", rdata); end
    @(negedge clk);
  endtask
`endif

  task automatic test_random();
    int owner, last, waitc, cand;
    bit busy, picked;
    logic [31:0] mRdata;
    logic [N-1:0] mAck, mErr, nAck, nErr, expG;
    do_reset();
    owner = -1; last = N - 1; busy = 0; waitc = 0; mRdata = '0; mAck = '0; mErr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      expG = (owner >= 0) ? 4'(4'b0001 << owner) : 4'b0000;
      checks++; if (grant !== expG) begin errors++; $display("FAIL rand_grant cyc=%0d: got %b want %b", cyc, grant, expG); end
      checks++; if (ack !== mAck || err !== mErr) begin errors++; $display("FAIL rand_ack_err cyc=%0d: got %b/%b want %b/%b", cyc, ack, err, mAck, mErr); end
      checks++; if (rdata !== mRdata || busValid !== busy) begin errors++; $display("FAIL rand_rdata_valid cyc=%0d: got %h/%b want %h/%b", cyc, rdata, busValid, mRdata, busy); end
      for (int k = 0; k < N; k++) begin
        if (busy && owner == k) begin
          req[k] = 1'b1;
        end else begin
          req[k]  = ($urandom_range(0, 1) == 0);
          lock[k] = ($urandom_range(0, 3) == 0);
          wr[k]   = $urandom_range(0, 1);
          addr[k*AW +: AW] = AW'($urandom);
          data[k*DW +: DW] = DW'($urandom);
        end
      end
      if (owner >= 0 && !busy) lock[owner] = ($urandom_range(0, 2) != 0);
      ready = ($urandom_range(0, 2) == 0);
      miso  = $urandom;
      #1;
      if (busy) begin
        checks++; if (busAddr !== addr[owner*AW +: AW] || busData !== data[owner*DW +: DW] || busWrite !== wr[owner]) begin errors++; $display("FAIL rand_bus cyc=%0d: got %h/%h/%b want %h/%h/%b", cyc, busAddr, busData, busWrite, addr[owner*AW +: AW], data[owner*DW +: DW], wr[owner]); end
      end else begin
        checks++; if ({busAddr, busData, busWrite} !== '0) begin errors++; $display("FAIL rand_bus_idle cyc=%0d: got %h/%h/%b want zeros", cyc, busAddr, busData, busWrite); end
      end
      nAck = '0; nErr = '0;
      if (owner < 0) begin
        picked = 0;
        for (int i = 1; i <= N; i++) begin
          cand = (last + i) % N;
          if (!picked && req[cand]) begin picked = 1; owner = cand; busy = 1; waitc = 0; end
        end
      end else if (busy) begin
        if (ready) begin
          nAck[owner] = 1'b1; mRdata = miso; last = owner; busy = 0;
          if (!lock[owner]) owner = -1;
        end else begin
`ifdef ARB_TIMEOUT_EN
          if (waitc == TO - 1) begin
            nErr[owner] = 1'b1; last = owner; busy = 0; owner = -1;
          end else begin
            waitc++;
          end
`endif
        end
      end else begin
        if (req[owner]) begin busy = 1; waitc = 0; end
        else if (!lock[owner]) owner = -1;
      end
      mAck = nAck; mErr = nErr;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_reset_mid_access();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
    test_timeout_tie();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
